// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives a single-request data-memory channel, stalls the
// front of the pipeline while a load/store is in flight, and feeds MEM/WB.
module mem_access_stage #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc_in,
    input  logic        zero_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] read_data2_in,
    input  logic [4:0]  write_reg_in,
    input  logic        branch_in,
    input  logic        memwrite_in,
    input  logic        memread_in,
    input  logic        memtoreg_in,
    input  logic        regwrite_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        pcsrc,
    output logic [63:0] branch_target,
    output logic [31:0] wb_read_data,
    output logic [31:0] wb_alu_result,
    output logic [4:0]  wb_write_reg,
    output logic        wb_memtoreg,
    output logic        wb_regwrite,
    output logic        mem_err
);
    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wait_q, wait_d, wait_inc;
    logic               mem_err_q, mem_err_d;
    logic [31:0]        req_addr_q, req_addr_d;
    logic [31:0]        req_wdata_q, req_wdata_d;
    logic               req_we_q, req_we_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        wb_read_data_q, wb_read_data_d;
    logic [31:0]        wb_alu_result_q, wb_alu_result_d;
    logic [4:0]         wb_write_reg_q, wb_write_reg_d;
    logic               wb_memtoreg_q, wb_memtoreg_d;
    logic               wb_regwrite_q, wb_regwrite_d;
    logic               mem_op;

    assign mem_op   = memread_in | memwrite_in;
    assign wait_inc = wait_q + CNT_W'(1);

    always_comb begin
        state_d         = state_q;
        wait_d          = wait_q;
        mem_err_d       = mem_err_q;
        req_addr_d      = req_addr_q;
        req_wdata_d     = req_wdata_q;
        req_we_d        = req_we_q;
        rdata_d         = rdata_q;
        wb_read_data_d  = wb_read_data_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_write_reg_d  = wb_write_reg_q;
        wb_memtoreg_d   = wb_memtoreg_q;
        wb_regwrite_d   = wb_regwrite_q;

        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    req_addr_d    = alu_result_in;
                    req_wdata_d   = read_data2_in;
                    req_we_d      = memwrite_in;
                    wb_regwrite_d = 1'b0;
                    state_d       = REQ;
                end else begin
                    wb_read_data_d  = 32'd0;
                    wb_alu_result_d = alu_result_in;
                    wb_write_reg_d  = write_reg_in;
                    wb_memtoreg_d   = memtoreg_in;
                    wb_regwrite_d   = regwrite_in;
                end
            end
            REQ: begin
                wb_regwrite_d = 1'b0;
                // A response on the timeout edge still counts as a success.
                if (dmem_ready) begin
                    rdata_d = req_we_q ? 32'd0 : dmem_rdata;
                    wait_d  = '0;
                    state_d = RESP;
                end else if (wait_inc == CNT_W'(MAX_WAIT)) begin
                    mem_err_d = 1'b1;
                    rdata_d   = 32'd0;
                    wait_d    = '0;
                    state_d   = RESP;
                end else begin
                    wait_d = wait_inc;
                end
            end
            RESP: begin
                wb_read_data_d  = rdata_q;
                wb_alu_result_d = alu_result_in;
                wb_write_reg_d  = write_reg_in;
                wb_memtoreg_d   = memtoreg_in;
                wb_regwrite_d   = regwrite_in;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            wait_q          <= '0;
            mem_err_q       <= 1'b0;
            req_addr_q      <= 32'd0;
            req_wdata_q     <= 32'd0;
            req_we_q        <= 1'b0;
            rdata_q         <= 32'd0;
            wb_read_data_q  <= 32'd0;
            wb_alu_result_q <= 32'd0;
            wb_write_reg_q  <= 5'd0;
            wb_memtoreg_q   <= 1'b0;
            wb_regwrite_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            wait_q          <= wait_d;
            mem_err_q       <= mem_err_d;
            req_addr_q      <= req_addr_d;
            req_wdata_q     <= req_wdata_d;
            req_we_q        <= req_we_d;
            rdata_q         <= rdata_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_write_reg_q  <= wb_write_reg_d;
            wb_memtoreg_q   <= wb_memtoreg_d;
            wb_regwrite_q   <= wb_regwrite_d;
        end
    end

    assign dmem_req      = (state_q == REQ);
    assign dmem_we       = (state_q == REQ) & req_we_q;
    assign dmem_addr     = req_addr_q;
    assign dmem_wdata    = req_wdata_q;
    assign stall         = ((state_q == IDLE) & mem_op) | (state_q == REQ);
    assign pcsrc         = branch_in & zero_in & (state_q == IDLE);
    assign branch_target = pc_in;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_write_reg  = wb_write_reg_q;
    assign wb_memtoreg   = wb_memtoreg_q;
    assign wb_regwrite   = wb_regwrite_q;
    assign mem_err       = mem_err_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed and random ALU/load/store transactions
// against a transaction-level expectation of the MEM/WB results.
module tb_mem_access_stage;
    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc_in;
    logic        zero_in, branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in;
    logic [31:0] alu_result_in, read_data2_in;
    logic [4:0]  write_reg_in;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        stall, pcsrc;
    logic [63:0] branch_target;
    logic [31:0] wb_read_data, wb_alu_result;
    logic [4:0]  wb_write_reg;
    logic        wb_memtoreg, wb_regwrite, mem_err;

    int n_vec = 0;
    int n_err = 0;

    // Expected MEM/WB contents and sticky error flag
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wr;
    logic        e_mtr, e_rw, e_err;

    mem_access_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .zero_in(zero_in),
        .alu_result_in(alu_result_in), .read_data2_in(read_data2_in),
        .write_reg_in(write_reg_in), .branch_in(branch_in),
        .memwrite_in(memwrite_in), .memread_in(memread_in),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
        .wb_write_reg(wb_write_reg), .wb_memtoreg(wb_memtoreg),
        .wb_regwrite(wb_regwrite), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag);
        chk({tag, ".rd"},  64'(wb_read_data),  64'(e_rd));
        chk({tag, ".alu"}, 64'(wb_alu_result), 64'(e_alu));
        chk({tag, ".wr"},  64'(wb_write_reg),  64'(e_wr));
        chk({tag, ".mtr"}, 64'(wb_memtoreg),   64'(e_mtr));
        chk({tag, ".rw"},  64'(wb_regwrite),   64'(e_rw));
        chk({tag, ".err"}, 64'(mem_err),       64'(e_err));
    endtask

    // Non-memory instruction: visible in MEM/WB one edge later, no stall.
    task automatic do_alu(input logic [31:0] alu, input logic [4:0] wr, input logic rw,
                          input logic mtr, input logic br, input logic zr, input logic [63:0] pc);
        @(negedge clk);
        alu_result_in = alu; read_data2_in = $urandom; write_reg_in = wr;
        regwrite_in = rw; memtoreg_in = mtr; memread_in = 1'b0; memwrite_in = 1'b0;
        branch_in = br; zero_in = zr; pc_in = pc; dmem_ready = 1'($urandom); dmem_rdata = $urandom;
        #1;
        chk("alu.stall", 64'(stall), 64'd0);
        chk("alu.req", 64'(dmem_req), 64'd0);
        chk("alu.pcsrc", 64'(pcsrc), 64'(br & zr));
        chk("alu.tgt", branch_target, pc);
        @(posedge clk); #1;
        e_rd = 32'd0; e_alu = alu; e_wr = wr; e_rw = rw; e_mtr = mtr;
        chk_wb("alu.wb");
    endtask

    // Load/store: memory answers after 'd' idle REQ cycles (d >= MAX_WAIT: never).
    task automatic do_mem(input logic st, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int d, input logic [4:0] wr,
                          input logic rw, input logic mtr);
        int  nreq;
        logic tmo;
        logic [63:0] pc;
        tmo  = (d >= MAX_WAIT);
        nreq = tmo ? MAX_WAIT : d + 1;
        @(negedge clk);
        alu_result_in = addr; read_data2_in = wdata; write_reg_in = wr;
        regwrite_in = rw; memtoreg_in = mtr; memread_in = ~st; memwrite_in = st;
        branch_in = 1'b1; zero_in = 1'b1; pc_in = 64'h100; dmem_ready = 1'b0;
        #1;
        chk("mem.idle.stall", 64'(stall), 64'd1);
        chk("mem.idle.req", 64'(dmem_req), 64'd0);
        chk("mem.idle.pcsrc", 64'(pcsrc), 64'd1);
        @(posedge clk); #1;
        e_rw = 1'b0;
        chk_wb("mem.bubble");
        for (int i = 1; i <= nreq; i++) begin
            @(negedge clk);
            // The request must come from the latched copy, not the live inputs.
            alu_result_in = $urandom; read_data2_in = $urandom; memwrite_in = 1'($urandom);
            branch_in = (i == 1) ? 1'b1 : 1'($urandom);
            zero_in = (i == 1) ? 1'b1 : 1'($urandom);
            pc = {32'd0, $urandom}; pc_in = pc;
            dmem_ready = (!tmo && i == d + 1);
            dmem_rdata = dmem_ready ? rdata : $urandom;
            #1;
            chk("req.req", 64'(dmem_req), 64'd1);
            chk("req.we", 64'(dmem_we), 64'(st));
            chk("req.addr", 64'(dmem_addr), 64'(addr));
            chk("req.wdata", 64'(dmem_wdata), 64'(wdata));
            chk("req.stall", 64'(stall), 64'd1);
            chk("req.pcsrc", 64'(pcsrc), 64'd0);
            chk("req.tgt", branch_target, pc);
            @(posedge clk); #1;
            if (i == nreq && tmo) e_err = 1'b1;
            chk_wb("req.wb");
        end
        @(negedge clk);
        alu_result_in = addr; read_data2_in = wdata; memread_in = ~st; memwrite_in = st;
        branch_in = 1'b1; zero_in = 1'b1; dmem_ready = 1'($urandom); dmem_rdata = $urandom;
        #1;
        chk("resp.req", 64'(dmem_req), 64'd0);
        chk("resp.we", 64'(dmem_we), 64'd0);
        chk("resp.stall", 64'(stall), 64'd0);
        chk("resp.pcsrc", 64'(pcsrc), 64'd0);
        @(posedge clk); #1;
        e_rd = (st || tmo) ? 32'd0 : rdata; e_alu = addr; e_wr = wr; e_rw = rw; e_mtr = mtr;
        chk_wb("resp.wb");
    endtask

    task automatic rand_txn(input int dmax);
        if ($urandom_range(0, 2) == 0)
            do_alu($urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), {$urandom, $urandom});
        else
            do_mem(1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, dmax),
                   5'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        rst = 1'b0; pc_in = '0; zero_in = 0; branch_in = 0; memwrite_in = 0; memread_in = 0;
        memtoreg_in = 0; regwrite_in = 0; alu_result_in = '0; read_data2_in = '0;
        write_reg_in = '0; dmem_ready = 0; dmem_rdata = '0;
        e_rd = '0; e_alu = '0; e_wr = '0; e_mtr = 0; e_rw = 0; e_err = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_wb("reset");
        chk("reset.req", 64'(dmem_req), 64'd0);
        chk("reset.we", 64'(dmem_we), 64'd0);
        chk("reset.stall", 64'(stall), 64'd0);
        @(negedge clk); rst = 1'b1;

        do_alu(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
        do_alu(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h100);
        do_mem(1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 0, 5'd7, 1'b1, 1'b1);
        do_mem(1'b1, 32'h80, 32'hA5A5A5A5, 32'h12345678, 3, 5'd0, 1'b0, 1'b0);
        do_mem(1'b0, 32'hC0, 32'h0, 32'hCAFEF00D, MAX_WAIT - 1, 5'd9, 1'b1, 1'b1);
        for (int k = 0; k < 30; k++) rand_txn(MAX_WAIT - 2);
        do_mem(1'b0, 32'h44, 32'h0, 32'h0BADF00D, MAX_WAIT + 5, 5'd3, 1'b1, 1'b1);
        for (int k = 0; k < 15; k++) rand_txn(MAX_WAIT + 3);

        // Reset during the second REQ cycle of a load
        @(negedge clk);
        alu_result_in = 32'h300; memread_in = 1'b1; memwrite_in = 1'b0; dmem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); dmem_ready = 1'b0; #1;
        chk("rst.req1", 64'(dmem_req), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'h55;
        @(posedge clk); #1;
        e_rd = '0; e_alu = '0; e_wr = '0; e_mtr = 0; e_rw = 0; e_err = 0;
        chk_wb("rst.wb");
        chk("rst.req", 64'(dmem_req), 64'd0);
        chk("rst.stall", 64'(stall), 64'd1);
        @(negedge clk); rst = 1'b1; memread_in = 1'b0;
        do_alu(32'hABCD, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 64'h200);
        for (int k = 0; k < 20; k++) rand_txn(MAX_WAIT + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum consecutive REQ cycles without dmem_ready before timeout.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 pc_in  in  64; zero_in  in  1; alu_result_in  in  32; read_data2_in  in  32; write_reg_in  in  5: EX/MEM register data fields.
REQ-005 branch_in, memwrite_in, memread_in, memtoreg_in, regwrite_in  in  1 each: EX/MEM control fields.
REQ-006 dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32; dmem_wdata  out  32: data-memory request channel.
REQ-007 dmem_ready  in  1; dmem_rdata  in  32: data-memory response (rdata valid when ready high).
REQ-008 stall  out  1: holds the EX/MEM register and earlier stages when high.
REQ-009 pcsrc  out  1; branch_target  out  64: branch resolution to fetch.
REQ-010 wb_read_data  out  32; wb_alu_result  out  32; wb_write_reg  out  5; wb_memtoreg  out  1; wb_regwrite  out  1: MEM/WB register outputs.
REQ-011 mem_err  out  1: sticky timeout flag.

Function
REQ-012 FSM states IDLE, REQ, RESP; reset state IDLE.
REQ-013 IDLE, memread_in|memwrite_in = 1: latch alu_result_in, read_data2_in, memwrite_in into request registers, go REQ.
REQ-014 IDLE, no memory op: stay IDLE; MEM/WB loads input fields on the edge; wb_read_data loads 0.
REQ-015 REQ: dmem_req=1, dmem_we=latched memwrite, dmem_addr/dmem_wdata = latched values, all stable until exit.
REQ-016 REQ, dmem_ready=1 at edge: capture dmem_rdata (0 for stores), clear wait counter, go RESP.
REQ-017 REQ, dmem_ready=0: wait counter +1; when counter reaches MAX_WAIT, set mem_err, capture 0, go RESP.
REQ-018 dmem_ready=1 on the same edge the counter reaches MAX_WAIT: ready wins, mem_err not set.
REQ-019 RESP: dmem_req=0, stall=0; MEM/WB loads captured data plus current input fields on the edge; go IDLE unconditionally.
REQ-020 stall = (IDLE & (memread_in|memwrite_in)) | REQ, combinational.
REQ-021 Any edge with stall=1: wb_regwrite<=0 (bubble), other wb_* fields hold.
REQ-022 dmem_req=0 and dmem_we=0 in IDLE and RESP; dmem_ready outside REQ ignored.
REQ-023 pcsrc = branch_in & zero_in & (state==IDLE); branch_target = pc_in, combinational.
REQ-024 Latency: non-memory op, wb_* valid 1 cycle after IDLE presentation; memory op with immediate ready, 3 cycles (IDLE, REQ, RESP).
REQ-025 mem_err stays 1 until reset; the pipeline continues after timeout.

Reset
REQ-026 rst=0 at an edge: state IDLE, wait counter 0, mem_err 0, request registers 0, all wb_* 0; reset overrides any in-flight REQ (dmem_req low the following cycle).
REQ-027 Combinational outputs during reset follow REQ-020/REQ-023 from the reset state.

Verification
REQ-028 ALU op alu_result_in=0x1234, write_reg_in=5, regwrite_in=1 in IDLE -> next cycle wb_alu_result=0x1234, wb_write_reg=5, wb_regwrite=1, stall never high.
REQ-029 Load addr 0x40, dmem_ready=1 with rdata=0xDEADBEEF in first REQ cycle -> stall high 2 cycles, wb_read_data=0xDEADBEEF after RESP edge, wb_regwrite=0 during stall.
REQ-030 Store addr 0x80, data 0xA5A5A5A5, ready after 3 wait cycles -> dmem_we=1, addr and data stable for all 4 REQ cycles, mem_err=0.
REQ-031 Load, dmem_ready never asserted, MAX_WAIT=15 -> RESP after 15 REQ cycles, mem_err=1 sticky, wb_read_data=0.
REQ-032 rst low during the 2nd REQ cycle -> dmem_req=0 next cycle, all wb_* 0, mem_err 0, then normal ALU op completes.
REQ-033 branch_in=1, zero_in=1, pc_in=0x100 in IDLE -> pcsrc=1, branch_target=0x100; same inputs in REQ -> pcsrc=0.
